// File: rtl/control_pkg.sv
// Shared definitions for the multi-cycle control unit.
//   state_t    : FSM state encoding
//   OPC_*      : 7-bit major opcodes accepted by the unit
//   op_class_t : one-hot opcode classification from opcode_decoder
//   ctrl_t     : bundle of all datapath strobes driven by control_unit
package control_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM_RD  = 3'd3,
    MEM_WR  = 3'd4,
    TRAP    = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LOAD       = 7'b0000011;
  localparam logic [6:0] OPC_STORE      = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM     = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32  = 7'b0011011;
  localparam logic [6:0] OPC_OP         = 7'b0110011;
  localparam logic [6:0] OPC_OP_32      = 7'b0111011;
  localparam logic [6:0] OPC_LUI        = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC      = 7'b0010111;
  localparam logic [6:0] OPC_JAL        = 7'b1101111;
  localparam logic [6:0] OPC_JALR       = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH     = 7'b1100011;

  // Regfile write-data source
  localparam logic [1:0] RF_DATA_IN = 2'b00;
  localparam logic [1:0] RF_ULA     = 2'b01;
  localparam logic [1:0] RF_PC4     = 2'b10;
  localparam logic [1:0] RF_SEC     = 2'b11;

  typedef struct packed {
    logic rtype;
    logic itype;
    logic load;
    logic store;
    logic lui;
    logic auipc;
    logic jal;
    logic jalr;
    logic branch;
    logic illegal;
  } op_class_t;

  typedef struct packed {
    logic       we_rf;
    logic       ula_din2_sel;
    logic       addr_sel;
    logic       load_pc;
    logic       load_ir;
    logic       pc_next_sel;
    logic       pc_adder_sel;
    logic       branch;
    logic [1:0] rf_din_sel;
    logic       mem_rd;
    logic       mem_wr;
  } ctrl_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier.
//   opcode : instruction[6:0]
//   cls    : one-hot class; illegal set for any unsupported opcode
module opcode_decoder
  import control_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OPC_OP, OPC_OP_32:         cls.rtype   = 1'b1;
      OPC_OP_IMM, OPC_OP_IMM_32: cls.itype   = 1'b1;
      OPC_LOAD:                  cls.load    = 1'b1;
      OPC_STORE:                 cls.store   = 1'b1;
      OPC_LUI:                   cls.lui     = 1'b1;
      OPC_AUIPC:                 cls.auipc   = 1'b1;
      OPC_JAL:                   cls.jal     = 1'b1;
      OPC_JALR:                  cls.jalr    = 1'b1;
      OPC_BRANCH:                cls.branch  = 1'b1;
      default:                   cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle Moore control unit: FETCH -> DECODE -> EXECUTE [-> MEM_RD/MEM_WR].
// Strobes decode from the state and the opcode class latched in DECODE; the
// only input qualifying them is mem_ready inside the three memory-wait states.
//
// Ports
//   CLK, RST_n            : clock, async active-low reset
//   opcode[6:0]           : IR opcode field (valid from DECODE onward)
//   mem_ready             : memory completes the pending access this cycle
//   WE_RF .. branch       : datapath control strobes
//   RF_din_sel[1:0]       : regfile write source (00 mem, 01 ULA, 10 PC+4, 11 sec adder)
//   mem_rd, mem_wr        : memory request, held until mem_ready
//   illegal, bus_err      : sticky error flags, cleared by reset only
//
// Build option: define CONTROL_UNIT_TIMEOUT_EN to add a wait counter that
// traps after TIMEOUT_CYCLES cycles without mem_ready and raises bus_err.
module control_unit
  import control_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       WE_RF,
  output logic       ULA_din2_sel,
  output logic       addr_sel,
  output logic       load_pc,
  output logic       load_ir,
  output logic       pc_next_sel,
  output logic       pc_adder_sel,
  output logic       branch,
  output logic [1:0] RF_din_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       illegal,
  output logic       bus_err
);

  state_t    state_q, state_d;
  op_class_t cls_in, cls_q;
  ctrl_t     ctrl, ctrl_out;
  logic      run_q;
  logic      illegal_q;
  logic      timeout;

  opcode_decoder u_dec (
    .opcode (opcode),
    .cls    (cls_in)
  );

  // run_q holds the outputs quiet from reset release until the first edge,
  // so FETCH visibly begins on that edge rather than during reset release.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= FETCH;
      cls_q     <= '0;
      run_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      if (state_q == DECODE) begin
        cls_q <= cls_in;
        if (cls_in.illegal) illegal_q <= 1'b1;
      end
    end
  end

`ifdef CONTROL_UNIT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic          waiting;
  logic [CW-1:0] wait_cnt;
  logic          bus_err_q;

  assign waiting = run_q && (state_q inside {FETCH, MEM_RD, MEM_WR});
  // Fires on the last permitted idle cycle so the wait lasts exactly
  // TIMEOUT_CYCLES cycles before TRAP.
  assign timeout = waiting && !mem_ready && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (state_q != state_d)       wait_cnt <= '0;
      else if (waiting && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
      if (timeout) bus_err_q <= 1'b1;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  // Next state
  always_comb begin
    state_d = state_q;
    if (run_q) begin
      case (state_q)
        FETCH: begin
          if (mem_ready)    state_d = DECODE;
          else if (timeout) state_d = TRAP;
        end
        DECODE:  state_d = cls_in.illegal ? TRAP : EXECUTE;
        EXECUTE: begin
          if (cls_q.load)         state_d = MEM_RD;
          else if (cls_q.store)   state_d = MEM_WR;
          else if (cls_q.illegal) state_d = TRAP;
          else                    state_d = FETCH;
        end
        MEM_RD, MEM_WR: begin
          if (mem_ready)    state_d = FETCH;
          else if (timeout) state_d = TRAP;
        end
        TRAP:    state_d = TRAP;
        default: state_d = FETCH;
      endcase
    end
  end

  // Strobes
  always_comb begin
    ctrl = '0;
    case (state_q)
      FETCH: begin
        ctrl.addr_sel = 1'b1;
        ctrl.mem_rd   = 1'b1;
        ctrl.load_ir  = mem_ready;
      end
      EXECUTE: begin
        if (cls_q.rtype) begin
          ctrl.we_rf      = 1'b1;
          ctrl.rf_din_sel = RF_ULA;
          ctrl.load_pc    = 1'b1;
        end
        if (cls_q.itype || cls_q.lui) begin
          ctrl.we_rf        = 1'b1;
          ctrl.rf_din_sel   = RF_ULA;
          ctrl.ula_din2_sel = 1'b1;
          ctrl.load_pc      = 1'b1;
        end
        if (cls_q.auipc) begin
          ctrl.we_rf      = 1'b1;
          ctrl.rf_din_sel = RF_SEC;
          ctrl.load_pc    = 1'b1;
        end
        if (cls_q.jal || cls_q.jalr) begin
          ctrl.we_rf        = 1'b1;
          ctrl.rf_din_sel   = RF_PC4;
          ctrl.load_pc      = 1'b1;
          ctrl.pc_next_sel  = 1'b1;
          ctrl.pc_adder_sel = cls_q.jalr;
        end
        if (cls_q.branch) begin
          ctrl.load_pc     = 1'b1;
          ctrl.branch      = 1'b1;
          ctrl.pc_next_sel = 1'b1;
        end
        // Address is computed here and held through the memory state.
        if (cls_q.load || cls_q.store) ctrl.ula_din2_sel = 1'b1;
      end
      MEM_RD: begin
        ctrl.mem_rd = 1'b1;
        if (mem_ready) begin
          ctrl.we_rf      = 1'b1;
          ctrl.rf_din_sel = RF_DATA_IN;
          ctrl.load_pc    = 1'b1;
        end
      end
      MEM_WR: begin
        ctrl.mem_wr = 1'b1;
        if (mem_ready) ctrl.load_pc = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign ctrl_out = run_q ? ctrl : '0;

  assign WE_RF        = ctrl_out.we_rf;
  assign ULA_din2_sel = ctrl_out.ula_din2_sel;
  assign addr_sel     = ctrl_out.addr_sel;
  assign load_pc      = ctrl_out.load_pc;
  assign load_ir      = ctrl_out.load_ir;
  assign pc_next_sel  = ctrl_out.pc_next_sel;
  assign pc_adder_sel = ctrl_out.pc_adder_sel;
  assign branch       = ctrl_out.branch;
  assign RF_din_sel   = ctrl_out.rf_din_sel;
  assign mem_rd       = ctrl_out.mem_rd;
  assign mem_wr       = ctrl_out.mem_wr;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit. A per-instruction reference model
// expands each opcode into its expected cycle-by-cycle strobe trace plus the
// mem_ready/opcode stimulus plan; tests replay the plan and compare.
module tb_control_unit;

  localparam int TO = 4;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       WE_RF, ULA_din2_sel, addr_sel, load_pc, load_ir;
  logic       pc_next_sel, pc_adder_sel, branch, mem_rd, mem_wr;
  logic [1:0] RF_din_sel;
  logic       illegal, bus_err;

  control_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST_n(RST_n), .opcode(opcode), .mem_ready(mem_ready),
    .WE_RF(WE_RF), .ULA_din2_sel(ULA_din2_sel), .addr_sel(addr_sel),
    .load_pc(load_pc), .load_ir(load_ir), .pc_next_sel(pc_next_sel),
    .pc_adder_sel(pc_adder_sel), .branch(branch), .RF_din_sel(RF_din_sel),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  // {WE_RF, din2, addr_sel, load_pc, load_ir, pc_next, pc_adder, branch, RF_din_sel, mem_rd, mem_wr}
  logic [11:0] vec;
  assign vec = {WE_RF, ULA_din2_sel, addr_sel, load_pc, load_ir, pc_next_sel,
                pc_adder_sel, branch, RF_din_sel, mem_rd, mem_wr};

  int errors = 0;
  int checks = 0;

  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];
  logic        rdy_q[$];
  logic [6:0]  opc_q[$];

  logic [6:0] legal_ops [11] = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0011011,
                                 7'b0110011, 7'b0111011, 7'b0110111, 7'b0010111,
                                 7'b1101111, 7'b1100111, 7'b1100011};

  function automatic logic [11:0] mk(input bit we, d2, as, lpc, lir, pns, pas, br,
                                     input bit [1:0] sel, input bit rd, wr);
    return {we, d2, as, lpc, lir, pns, pas, br, sel, rd, wr};
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Strobes expected in the EXECUTE cycle, straight from the instruction table.
  function automatic logic [11:0] exec_vec(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0111011:             return mk(1,0,0,1,0,0,0,0,2'b01,0,0);
      7'b0010011, 7'b0011011, 7'b0110111: return mk(1,1,0,1,0,0,0,0,2'b01,0,0);
      7'b0010111:                         return mk(1,0,0,1,0,0,0,0,2'b11,0,0);
      7'b1101111:                         return mk(1,0,0,1,0,1,0,0,2'b10,0,0);
      7'b1100111:                         return mk(1,0,0,1,0,1,1,0,2'b10,0,0);
      7'b1100011:                         return mk(0,0,0,1,0,1,0,1,2'b00,0,0);
      7'b0000011, 7'b0100011:             return mk(0,1,0,0,0,0,0,0,2'b00,0,0);
      default:                            return '0;
    endcase
  endfunction

  function automatic logic [6:0] noise();
    return 7'($urandom);
  endfunction

  // Expected trace for one instruction: fw idle fetch cycles, mw idle memory
  // cycles, trap_cycles of observation after an illegal decode.
  task automatic build(input logic [6:0] op, input int fw, input int mw, input int trap_cycles);
    exp_q.delete(); rdy_q.delete(); opc_q.delete();
    for (int i = 0; i < fw; i++) begin
      exp_q.push_back(mk(0,0,1,0,0,0,0,0,2'b00,1,0)); rdy_q.push_back(1'b0); opc_q.push_back(noise());
    end
    exp_q.push_back(mk(0,0,1,0,1,0,0,0,2'b00,1,0)); rdy_q.push_back(1'b1); opc_q.push_back(noise());
    exp_q.push_back('0); rdy_q.push_back(1'($urandom)); opc_q.push_back(op);
    if (!is_legal(op)) begin
      for (int i = 0; i < trap_cycles; i++) begin
        exp_q.push_back('0); rdy_q.push_back(1'($urandom)); opc_q.push_back(noise());
      end
    end else begin
      exp_q.push_back(exec_vec(op)); rdy_q.push_back(1'($urandom)); opc_q.push_back(noise());
      if (op == 7'b0000011) begin
        for (int i = 0; i < mw; i++) begin
          exp_q.push_back(mk(0,0,0,0,0,0,0,0,2'b00,1,0)); rdy_q.push_back(1'b0); opc_q.push_back(noise());
        end
        exp_q.push_back(mk(1,0,0,1,0,0,0,0,2'b00,1,0)); rdy_q.push_back(1'b1); opc_q.push_back(noise());
      end else if (op == 7'b0100011) begin
        for (int i = 0; i < mw; i++) begin
          exp_q.push_back(mk(0,0,0,0,0,0,0,0,2'b00,0,1)); rdy_q.push_back(1'b0); opc_q.push_back(noise());
        end
        exp_q.push_back(mk(0,0,0,1,0,0,0,0,2'b00,0,1)); rdy_q.push_back(1'b1); opc_q.push_back(noise());
      end
    end
  endtask

  // Replay n planned cycles; entered and left at posedge+1.
  task automatic play(input int n);
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      mem_ready = rdy_q[i];
      opcode    = opc_q[i];
      @(negedge CLK);
      obs_q.push_back(vec);
      @(posedge CLK); #1;
    end
    mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    RST_n = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST_n = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST_n = 1'b0; mem_ready = 1'b1;
    #3;
    checks++;
    if ({vec, illegal, bus_err} !== 14'b0) begin
      errors++; $display("FAIL reset_hold got=%b want=0", {vec, illegal, bus_err});
    end
    mem_ready = 1'b0;
    @(negedge CLK); RST_n = 1'b1; #1;
    checks++;
    if (vec !== 12'b0) begin errors++; $display("FAIL reset_release_pre_edge got=%b want=0", vec); end
    @(posedge CLK); #1;
    checks++;
    if (vec !== mk(0,0,1,0,0,0,0,0,2'b00,1,0)) begin
      errors++; $display("FAIL reset_first_fetch got=%b want=%b", vec, mk(0,0,1,0,0,0,0,0,2'b00,1,0));
    end
  endtask

  task automatic test_addi();
    build(7'b0010011, 0, 0, 0);
    play(exp_q.size());
    checks++;
    if (exp_q.size() != 3) begin errors++; $display("FAIL addi_len got=%0d want=3", exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL addi cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_ld_wait();
    int rd_low = 0;
    build(7'b0000011, 1, 3, 0);
    play(exp_q.size());
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ld cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i][1] && !obs_q[i][9]) rd_low++;
    end
    checks++;
    if (rd_low != 4) begin errors++; $display("FAIL ld_memrd_cycles got=%0d want=4", rd_low); end
  endtask

  task automatic test_jalr();
    build(7'b1100111, 0, 0, 0);
    play(exp_q.size());
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL jalr cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [6:0] op;
      int lpc;
      op = legal_ops[$urandom_range(0, 10)];
      build(op, $urandom_range(0, 3), $urandom_range(0, 3), 0);
      play(exp_q.size());
      lpc = 0;
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d op=%b cyc%0d got=%b want=%b", n, op, i, obs_q[i], exp_q[i]);
        end
        if (obs_q[i][8]) lpc++;
      end
      checks++;
      if (lpc != 1) begin errors++; $display("FAIL rand%0d_load_pc_count got=%0d want=1", n, lpc); end
    end
  endtask

  task automatic test_illegal();
    build(7'b1111111, 1, 0, 20);
    play(exp_q.size());
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL illegal cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({illegal, bus_err} !== 2'b10) begin
      errors++; $display("FAIL illegal_flags got=%b want=10", {illegal, bus_err});
    end
    RST_n = 1'b0; #2;
    checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_clear got=%b want=0", illegal); end
    @(negedge CLK); RST_n = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (vec !== mk(0,0,1,0,0,0,0,0,2'b00,1,0)) begin
      errors++; $display("FAIL illegal_refetch got=%b want=%b", vec, mk(0,0,1,0,0,0,0,0,2'b00,1,0));
    end
  endtask

  task automatic test_async_reset();
    build(7'b0000011, 0, 5, 0);
    play(5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL arst_pre cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
      end
    end
    mem_ready = 1'b0;
    #2 RST_n = 1'b0;
    #1;
    checks++;
    if ({vec, illegal, bus_err} !== 14'b0) begin
      errors++; $display("FAIL arst_mid_memrd got=%b want=0", {vec, illegal, bus_err});
    end
    @(negedge CLK); RST_n = 1'b1; #1;
    checks++;
    if (vec !== 12'b0) begin errors++; $display("FAIL arst_release got=%b want=0", vec); end
    @(posedge CLK); #1;
    checks++;
    if (vec !== mk(0,0,1,0,0,0,0,0,2'b00,1,0)) begin
      errors++; $display("FAIL arst_fetch got=%b want=%b", vec, mk(0,0,1,0,0,0,0,0,2'b00,1,0));
    end
  endtask

  task automatic test_timeout();
`ifdef CONTROL_UNIT_TIMEOUT_EN
    build(7'b0100011, 0, 0, 0);
    play(3);
    for (int k = 0; k < TO; k++) begin
      mem_ready = 1'b0;
      @(negedge CLK);
      checks++;
      if ({mem_wr, bus_err} !== 2'b10) begin
        errors++; $display("FAIL timeout_wait%0d got=%b want=10", k, {mem_wr, bus_err});
      end
      @(posedge CLK); #1;
    end
    checks++;
    if ({vec, bus_err} !== 13'b1) begin
      errors++; $display("FAIL timeout_trap got=%b want=%b", {vec, bus_err}, 13'b1);
    end
    do_reset();
    checks++;
    if (bus_err !== 1'b0) begin errors++; $display("FAIL timeout_clear got=%b want=0", bus_err); end
`else
    build(7'b0100011, 2, 30, 0);
    play(exp_q.size());
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL longwait cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (bus_err !== 1'b0) begin errors++; $display("FAIL longwait_bus_err got=%b want=0", bus_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_addi();
    test_ld_wait();
    test_jalr();
    test_random();
    test_illegal();
    test_async_reset();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
